// File: rtl/axi_lite_apb_if.sv
// axi_lite_apb_if
// Bundles the AXI-Lite slave channels and the APB master signals of the
// AXI-Lite to APB bridge.
//   slave  modport : the bridge's view (AXI-Lite slave side, APB master side)
//   master modport : the environment's view (AXI-Lite master, APB completer)
// Parameters: ADDR_W address width, DATA_W data width (32).
interface axi_lite_apb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // AXI-Lite write address / data / response
  logic [ADDR_W-1:0]   s_awaddr;
  logic                s_awvalid;
  logic                s_awready;
  logic [DATA_W-1:0]   s_wdata;
  logic [DATA_W/8-1:0] s_wstrb;
  logic                s_wvalid;
  logic                s_wready;
  logic [1:0]          s_bresp;
  logic                s_bvalid;
  logic                s_bready;
  // AXI-Lite read address / data
  logic [ADDR_W-1:0]   s_araddr;
  logic                s_arvalid;
  logic                s_arready;
  logic [DATA_W-1:0]   s_rdata;
  logic [1:0]          s_rresp;
  logic                s_rvalid;
  logic                s_rready;
  // APB
  logic [ADDR_W-1:0]   paddr;
  logic                psel;
  logic                penable;
  logic                pwrite;
  logic [DATA_W-1:0]   pwdata;
  logic [DATA_W/8-1:0] pstrb;
  logic [DATA_W-1:0]   prdata;
  logic                pready;
  logic                pslverr;

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid,
    output s_arready, s_rdata, s_rresp, s_rvalid,
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid,
    input  s_arready, s_rdata, s_rresp, s_rvalid,
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/axi_lite_apb_bridge.sv
// axi_lite_apb_bridge
// Converts single AXI-Lite read/write transactions into APB transfers, one
// transaction in flight at a time.
// Ports:
//   aclk      : clock, all logic on the rising edge
//   areset_n  : asynchronous active-low reset
//   bus       : axi_lite_apb_if.slave (AXI-Lite slave + APB master signals)
//   dbg_state : current FSM state (0 IDLE, 1 SETUP, 2 ACCESS, 3 RESP)
// Handshakes: a transfer on any AXI channel happens on the rising edge where
// both valid and ready are high. Valids are never withdrawn by the bridge
// before the matching ready; readies here are only raised in IDLE and may
// depend combinationally on the incoming valids.
module axi_lite_apb_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic        aclk,
  input  logic        areset_n,
  axi_lite_apb_if.slave bus,
  output logic [1:0]  dbg_state
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] tmo_cnt;
  logic             prefer_write;  // 1: write wins the next tie
  logic             is_write;      // type of the transaction in flight

  logic wr_elig;
  logic rd_elig;
  logic grant_wr;
  logic grant_rd;
  logic tmo_hit;
  logic access_done;
  logic resp_done;
  logic done_err;

  // Arbitration: a write needs both address and data valid. On a tie the
  // type that was not served last wins.
  always_comb begin
    wr_elig  = bus.s_awvalid && bus.s_wvalid;
    rd_elig  = bus.s_arvalid;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (state == IDLE) begin
      grant_wr = wr_elig && (!rd_elig || prefer_write);
      grant_rd = rd_elig && (!wr_elig || !prefer_write);
    end
  end

  // The counter holds the number of ACCESS cycles already spent with pready
  // low, so the TIMEOUT-th low cycle is the one that forces completion.
  always_comb begin
    tmo_hit     = (state == ACCESS) && !bus.pready &&
                  (tmo_cnt == CNT_W'(TIMEOUT - 1));
    access_done = (state == ACCESS) && (bus.pready || tmo_hit);
    done_err    = bus.pready ? bus.pslverr : 1'b1;
    resp_done   = (state == RESP) && (is_write ? bus.s_bready : bus.s_rready);
  end

  // FSM: state register
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_wr || grant_rd) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (access_done) state_nxt = RESP;
      RESP:    if (resp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs decoded from state
  always_comb begin
    bus.s_awready = 1'b0;
    bus.s_wready  = 1'b0;
    bus.s_arready = 1'b0;
    bus.s_bvalid  = 1'b0;
    bus.s_rvalid  = 1'b0;
    bus.psel      = 1'b0;
    bus.penable   = 1'b0;
    case (state)
      IDLE: begin
        bus.s_awready = grant_wr;
        bus.s_wready  = grant_wr;
        bus.s_arready = grant_rd;
      end
      SETUP: begin
        bus.psel = 1'b1;
      end
      ACCESS: begin
        bus.psel    = 1'b1;
        bus.penable = 1'b1;
      end
      RESP: begin
        bus.s_bvalid = is_write;
        bus.s_rvalid = !is_write;
      end
      default: ;
    endcase
  end

  assign dbg_state = state;

  // Timeout counter: only advances while waiting in ACCESS.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      tmo_cnt <= '0;
    end else if ((state == ACCESS) && !access_done) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Request capture on acceptance; APB request fields then stay stable until
  // the next acceptance.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      bus.paddr    <= '0;
      bus.pwrite   <= 1'b0;
      bus.pwdata   <= '0;
      bus.pstrb    <= '0;
      is_write     <= 1'b0;
      prefer_write <= 1'b0;
    end else if (grant_wr || grant_rd) begin
      bus.paddr    <= grant_wr ? bus.s_awaddr : bus.s_araddr;
      bus.pwrite   <= grant_wr;
      bus.pwdata   <= grant_wr ? bus.s_wdata : {DATA_W{1'b0}};
      bus.pstrb    <= grant_wr ? bus.s_wstrb : {STRB_W{1'b0}};
      is_write     <= grant_wr;
      prefer_write <= grant_rd;
    end
  end

  // Response capture at the end of ACCESS; held through RESP. A timeout
  // reports SLVERR with zero read data.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      bus.s_bresp <= 2'b00;
      bus.s_rresp <= 2'b00;
      bus.s_rdata <= '0;
    end else if (access_done) begin
      if (is_write) begin
        bus.s_bresp <= done_err ? 2'b10 : 2'b00;
      end else begin
        bus.s_rresp <= done_err ? 2'b10 : 2'b00;
        bus.s_rdata <= bus.pready ? bus.prdata : {DATA_W{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_apb_bridge.sv
// tb_axi_lite_apb_bridge
// Directed and randomized transactions; an APB completer model answers with
// planned wait states, errors and read data, and monitors compare the APB
// request and the AXI response against queues filled at acceptance time.
module tb_axi_lite_apb_bridge;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int BUDGET  = 400;

  logic       aclk = 1'b0;
  logic       areset_n = 1'b0;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  axi_lite_apb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi_lite_apb_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .aclk(aclk),
    .areset_n(areset_n),
    .bus(bus.slave),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  // expected response: {valid_cycle[19:0], is_write, resp[1:0], rdata[31:0]}
  logic [54:0] exp_q[$];
  // expected APB request: {pwrite, paddr[31:0], pwdata[31:0], pstrb[3:0]}
  logic [68:0] apb_q[$];
  // completer plan: {waits[7:0], pslverr, prdata[31:0]}
  logic [40:0] plan_q[$];

  bit pref_write = 1'b0;  // model: next tie goes to a write
  int hold_b = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference model: the APB access lasts waits+1 cycles unless the slave
  // stays silent for TIMEOUT cycles, which yields SLVERR and zero data.
  function automatic logic [54:0] model_resp(input bit is_wr, input int waits,
                                             input bit err, input logic [31:0] data,
                                             input int t);
    int acc;
    logic [1:0] resp;
    logic [31:0] rd;
    if (waits < TIMEOUT) begin
      acc = waits + 1;
      resp = err ? 2'b10 : 2'b00;
      rd = data;
    end else begin
      acc = TIMEOUT;
      resp = 2'b10;
      rd = 32'h0;
    end
    if (is_wr) rd = 32'h0;
    return {20'(t + 2 + acc), is_wr, resp, rd};
  endfunction

  // driver: present a read and/or write and wait for their acceptance
  task automatic run_txns(input bit want_r, input bit want_w,
                          input logic [31:0] raddr, input int rwaits, input bit rerr,
                          input logic [31:0] rdata,
                          input logic [31:0] waddr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int wwaits, input bit werr);
    bit pend_r;
    bit pend_w;
    int budget;
    pend_r = want_r;
    pend_w = want_w;
    budget = 0;
    @(negedge aclk);
    bus.s_arvalid = want_r;
    bus.s_araddr  = raddr;
    bus.s_awvalid = want_w;
    bus.s_wvalid  = want_w;
    bus.s_awaddr  = waddr;
    bus.s_wdata   = wdata;
    bus.s_wstrb   = wstrb;
    while ((pend_r || pend_w) && budget < BUDGET) begin
      #1;
      if (bus.s_arready || bus.s_awready || bus.s_wready) begin
        bit got_w;
        got_w = bus.s_awready;
        check("aw_w_ready_pair", 64'(bus.s_wready), 64'(bus.s_awready));
        check("single_grant", 64'(bus.s_arready & bus.s_awready), 64'h0);
        if (pend_r && pend_w) check("arb_winner_is_write", 64'(got_w), 64'(pref_write));
        if (got_w) begin
          check("grant_w_requested", 64'(pend_w), 64'h1);
          plan_q.push_back({8'(wwaits), werr, 32'($urandom)});
          apb_q.push_back({1'b1, waddr, wdata, wstrb});
          exp_q.push_back(model_resp(1'b1, wwaits, werr, 32'h0, cyc));
          pend_w = 1'b0;
        end else begin
          check("grant_r_requested", 64'(pend_r), 64'h1);
          plan_q.push_back({8'(rwaits), rerr, rdata});
          apb_q.push_back({1'b0, raddr, 32'h0, 4'h0});
          exp_q.push_back(model_resp(1'b0, rwaits, rerr, rdata, cyc));
          pend_r = 1'b0;
        end
        pref_write = !got_w;
        @(posedge aclk);
        #1;
        if (got_w) begin
          bus.s_awvalid = 1'b0;
          bus.s_wvalid  = 1'b0;
        end else begin
          bus.s_arvalid = 1'b0;
        end
      end
      @(negedge aclk);
      budget++;
    end
    if (pend_r || pend_w) begin
      check("accept_timeout", 64'h1, 64'h0);
      bus.s_arvalid = 1'b0;
      bus.s_awvalid = 1'b0;
      bus.s_wvalid  = 1'b0;
    end
  endtask

  // APB completer model
  initial begin : apb_slave
    int k;
    int waits;
    bit err;
    logic [31:0] d;
    logic [40:0] p;
    k = 0;
    waits = 0;
    err = 1'b0;
    d = 32'h0;
    forever begin
      @(negedge aclk);
      if (areset_n && bus.psel && bus.penable) begin
        if (k == 0) begin
          if (plan_q.size() > 0) p = plan_q.pop_front();
          else begin
            check("apb_unplanned_access", 64'h1, 64'h0);
            p = '0;
          end
          waits = int'(p[40:33]);
          err = p[32];
          d = p[31:0];
        end
        bus.pready  = (k >= waits);
        bus.pslverr = err;
        bus.prdata  = d;
        k++;
      end else begin
        k = 0;
        bus.pready  = 1'($urandom_range(0, 1));
        bus.pslverr = 1'($urandom_range(0, 1));
        bus.prdata  = $urandom;
      end
    end
  end

  // response-ready driver
  initial begin : ready_drv
    forever begin
      @(negedge aclk);
      if (hold_b > 0) begin
        bus.s_bready = 1'b0;
        if (bus.s_bvalid) hold_b--;
      end else begin
        bus.s_bready = ($urandom_range(0, 3) != 0);
      end
      bus.s_rready = ($urandom_range(0, 3) != 0);
    end
  end

  // APB request monitor
  initial begin : apb_mon
    logic [68:0] cur;
    cur = '0;
    forever begin
      @(negedge aclk);
      #2;
      if (areset_n && bus.psel) begin
        if (!bus.penable) begin
          if (apb_q.size() == 0) begin
            check("apb_unexpected_setup", 64'h1, 64'h0);
            cur = '0;
          end else begin
            cur = apb_q.pop_front();
          end
        end
        check("pwrite", 64'(bus.pwrite), 64'(cur[68]));
        check("paddr", 64'(bus.paddr), 64'(cur[67:36]));
        check("pwdata", 64'(bus.pwdata), 64'(cur[35:4]));
        check("pstrb", 64'(bus.pstrb), 64'(cur[3:0]));
      end
    end
  end

  // scoreboard: AXI response monitor
  bit resp_active = 1'b0;
  initial begin : resp_mon
    logic [54:0] cur;
    cur = '0;
    forever begin
      @(negedge aclk);
      #2;
      if (!areset_n) begin
        resp_active = 1'b0;
      end else if (bus.s_bvalid || bus.s_rvalid) begin
        check("one_valid", 64'(bus.s_bvalid & bus.s_rvalid), 64'h0);
        check("no_accept_in_resp",
              64'({bus.s_awready, bus.s_wready, bus.s_arready}), 64'h0);
        if (!resp_active) begin
          if (exp_q.size() == 0) begin
            check("unexpected_resp", 64'h1, 64'h0);
            cur = '0;
          end else begin
            cur = exp_q.pop_front();
          end
          resp_active = 1'b1;
          check("valid_cycle", 64'(cyc[19:0]), 64'(cur[54:35]));
        end
        check("resp_is_write", 64'(bus.s_bvalid), 64'(cur[34]));
        if (cur[34]) begin
          check("bresp", 64'(bus.s_bresp), 64'(cur[33:32]));
        end else begin
          check("rresp", 64'(bus.s_rresp), 64'(cur[33:32]));
          check("rdata", 64'(bus.s_rdata), 64'(cur[31:0]));
        end
        if ((bus.s_bvalid && bus.s_bready) || (bus.s_rvalid && bus.s_rready))
          resp_active = 1'b0;
      end
    end
  end

  initial begin : main
    int b;
    bus.s_awaddr = '0; bus.s_awvalid = 1'b0; bus.s_wdata = '0; bus.s_wstrb = '0;
    bus.s_wvalid = 1'b0; bus.s_araddr = '0; bus.s_arvalid = 1'b0;
    bus.s_bready = 1'b0; bus.s_rready = 1'b0;
    bus.prdata = '0; bus.pready = 1'b0; bus.pslverr = 1'b0;
    areset_n = 1'b0;

    // reset values
    repeat (3) @(negedge aclk);
    #2;
    check("rst_state", 64'(dbg_state), 64'h0);
    check("rst_ready_valid", 64'({bus.s_awready, bus.s_wready, bus.s_arready,
                                   bus.s_bvalid, bus.s_rvalid}), 64'h0);
    check("rst_apb_ctl", 64'({bus.psel, bus.penable, bus.pwrite}), 64'h0);
    check("rst_paddr", 64'(bus.paddr), 64'h0);
    check("rst_pwdata_pstrb", 64'({bus.pwdata, bus.pstrb}), 64'h0);
    check("rst_rdata", 64'(bus.s_rdata), 64'h0);
    check("rst_resps", 64'({bus.s_bresp, bus.s_rresp}), 64'h0);
    @(negedge aclk);
    areset_n = 1'b1;

    // basic write, zero wait states
    run_txns(1'b0, 1'b1, 32'h0, 0, 1'b0, 32'h0,
             32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
    // read with 3 wait states
    run_txns(1'b1, 1'b0, 32'h0000_0004, 3, 1'b0, 32'h1234_5678,
             32'h0, 32'h0, 4'h0, 0, 1'b0);
    // slave errors
    run_txns(1'b1, 1'b0, 32'h0000_0100, 1, 1'b1, 32'hCAFE_F00D,
             32'h0, 32'h0, 4'h0, 0, 1'b0);
    run_txns(1'b0, 1'b1, 32'h0, 0, 1'b0, 32'h0,
             32'h0000_0104, 32'h5555_AAAA, 4'h3, 2, 1'b1);
    // timeouts: boundary just below, at, and well beyond
    run_txns(1'b1, 1'b0, 32'h0000_0200, TIMEOUT - 1, 1'b0, 32'hA5A5_0001,
             32'h0, 32'h0, 4'h0, 0, 1'b0);
    run_txns(1'b1, 1'b0, 32'h0000_0204, TIMEOUT, 1'b0, 32'hA5A5_0002,
             32'h0, 32'h0, 4'h0, 0, 1'b0);
    run_txns(1'b0, 1'b1, 32'h0, 0, 1'b0, 32'h0,
             32'h0000_0208, 32'h0BAD_0BAD, 4'h8, 40, 1'b0);

    // contention: both types pending together, repeatedly; a held-off bready
    for (int i = 0; i < 3; i++) begin
      if (i == 1) hold_b = 5;
      run_txns(1'b1, 1'b1, 32'h1000 + 32'(i * 8), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
               $urandom, 32'h2000 + 32'(i * 8), $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    // reset during ACCESS
    run_txns(1'b1, 1'b0, 32'h0000_0040, 30, 1'b0, 32'h7777_7777,
             32'h0, 32'h0, 4'h0, 0, 1'b0);
    b = 0;
    while (!(bus.psel && bus.penable) && b < BUDGET) begin
      @(negedge aclk);
      b++;
    end
    check("reached_access", 64'(bus.psel && bus.penable), 64'h1);
    repeat (2) @(negedge aclk);
    #3;
    areset_n = 1'b0;
    #1;
    check("rst_mid_psel_penable", 64'({bus.psel, bus.penable}), 64'h0);
    check("rst_mid_valids", 64'({bus.s_bvalid, bus.s_rvalid}), 64'h0);
    check("rst_mid_state", 64'(dbg_state), 64'h0);
    exp_q.delete();
    apb_q.delete();
    plan_q.delete();
    pref_write = 1'b0;
    hold_b = 0;
    repeat (2) @(negedge aclk);
    areset_n = 1'b1;
    // after reset a tie goes to the read first
    for (int i = 0; i < 2; i++) begin
      run_txns(1'b1, 1'b1, 32'h3000 + 32'(i), 0, 1'b0, $urandom,
               32'h3100 + 32'(i), $urandom, 4'hF, 1, 1'b0);
    end

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int mode;
      int rw;
      int ww;
      mode = $urandom_range(0, 2);
      rw = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 4) : $urandom_range(0, 4);
      ww = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 4) : $urandom_range(0, 4);
      run_txns(mode != 1, mode != 0, $urandom, rw, 1'($urandom_range(0, 1)), $urandom,
               $urandom, $urandom, 4'($urandom_range(0, 15)), ww, 1'($urandom_range(0, 1)));
    end

    // drain
    b = 0;
    while ((exp_q.size() != 0 || resp_active) && b < 2000) begin
      @(negedge aclk);
      b++;
    end
    repeat (2) @(negedge aclk);
    check("drain_exp_q", 64'(exp_q.size()), 64'h0);
    check("drain_apb_q", 64'(apb_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_apb_bridge.md
AXI_LITE_APB_BRIDGE -- requirements
Module: axi_lite_apb_bridge

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, address width; DATA_W, 32, data width, fixed 32; TIMEOUT, 16, maximum ACCESS cycles with pready low before forced error.
REQ-002 aclk  input  1  single clock; all logic rising-edge.
REQ-003 areset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 AXI-Lite slave write inputs SHALL be: s_awaddr in ADDR_W; s_awvalid in 1; s_wdata in 32; s_wstrb in 4; s_wvalid in 1; s_bready in 1.
REQ-005 AXI-Lite slave write outputs SHALL be: s_awready out 1; s_wready out 1; s_bresp out 2; s_bvalid out 1.
REQ-006 AXI-Lite slave read inputs SHALL be: s_araddr in ADDR_W; s_arvalid in 1; s_rready in 1.
REQ-007 AXI-Lite slave read outputs SHALL be: s_arready out 1; s_rdata out 32; s_rresp out 2; s_rvalid out 1.
REQ-008 APB master outputs SHALL be: paddr out ADDR_W; psel out 1; penable out 1; pwrite out 1; pwdata out 32; pstrb out 4.
REQ-009 APB master inputs SHALL be: prdata in 32; pready in 1; pslverr in 1.

Function
REQ-010 The FSM SHALL have states IDLE, SETUP, ACCESS, RESP; one transaction in flight; no AXI acceptance outside IDLE.
REQ-011 In IDLE, write is eligible only when s_awvalid and s_wvalid are both high; s_awready and s_wready SHALL pulse together for exactly one cycle on acceptance.
REQ-012 In IDLE, read is eligible when s_arvalid is high; s_arready SHALL pulse for one cycle on acceptance.
REQ-013 When read and write are both eligible, the type not served last SHALL win; after reset, read wins.
REQ-014 On acceptance at cycle T: paddr, pwrite, pwdata, pstrb SHALL be registered; state becomes SETUP at T+1 (psel=1, penable=0).
REQ-015 SETUP SHALL move unconditionally to ACCESS (psel=1, penable=1); paddr/pwrite/pwdata/pstrb stay stable through ACCESS.
REQ-016 ACCESS SHALL hold while pready=0; on pready=1, psel and penable drop the next cycle and state becomes RESP.
REQ-017 For reads, pwdata and pstrb SHALL be 0; pstrb for writes SHALL equal the captured s_wstrb.
REQ-018 On completion, s_rdata SHALL capture prdata (read) and response SHALL be 2'b10 (SLVERR) if pslverr=1, else 2'b00.
REQ-019 A timeout counter SHALL count ACCESS cycles with pready=0; when it reaches TIMEOUT, ACCESS ends as if pready=1 with pslverr=1, s_rdata=0.
REQ-020 In RESP, s_bvalid (write) or s_rvalid (read) SHALL be high and held with stable s_bresp/s_rresp/s_rdata until s_bready/s_rready; handshake cycle returns to IDLE.
REQ-021 Minimum latency, zero-wait-state slave: acceptance T, SETUP T+1, ACCESS T+2, valid at T+3.
REQ-022 A new acceptance SHALL be possible in the IDLE cycle following the response handshake (no back-to-back bypass).
REQ-023 AXI address bits SHALL pass unmodified to paddr; no alignment check.

Reset
REQ-024 On areset_n low, state SHALL be IDLE, timeout counter 0, arbitration flag = read-first, asynchronously.
REQ-025 Reset values: all ready/valid outputs 0; psel, penable, pwrite 0; paddr, pwdata, pstrb, s_rdata 0; s_bresp, s_rresp 2'b00.
REQ-026 Reset mid-transaction SHALL abort it with no response; first post-reset cycle is IDLE.

Verification
REQ-027 Write 0x0000_0010 data 0xDEAD_BEEF wstrb 0xF, pready=1 -> paddr=0x10, pwdata=0xDEADBEEF, pstrb=0xF, pwrite=1, s_bvalid at T+3, s_bresp=00.
REQ-028 Read 0x0000_0004, pready low 3 ACCESS cycles, prdata=0x1234_5678 -> s_rdata=0x12345678, s_rresp=00, s_rvalid at T+6.
REQ-029 Read with pslverr=1 -> s_rresp=10; write with pslverr=1 -> s_bresp=10.
REQ-030 pready held low, TIMEOUT=16 -> ACCESS exits after 16 cycles, s_rresp=10, s_rdata=0.
REQ-031 s_arvalid and both write valids high together, repeatedly -> grants alternate R,W,R,W; s_bready held low 5 cycles -> s_bvalid/s_bresp stable, no new acceptance.
REQ-032 areset_n low during ACCESS -> psel/penable 0 immediately, no s_bvalid/s_rvalid, next transfer completes normally.
